// File: rtl/branch_resolve_if.sv
// Branch request, redirect handshake and resolution status between the ALU
// compare path (master) and the branch resolution unit (slave).
interface branch_resolve_if;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_pc;
    logic [15:0] br_imm;
    logic        br_invert;
    logic        br_always;
    logic [31:0] cmp_s;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        resolved;
    logic        resolved_taken;

    modport master (
        output br_valid, br_pc, br_imm, br_invert, br_always, cmp_s, redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, flush, resolved, resolved_taken
    );

    modport slave (
        input  br_valid, br_pc, br_imm, br_invert, br_always, cmp_s, redirect_ready,
        output br_ready, redirect_valid, redirect_pc, flush, resolved, resolved_taken
    );
endinterface

// File: rtl/branch_resolve.sv
// Sequential branch resolution: decides taken/not-taken from a latched compare
// word, redirects fetch on taken branches and then holds a flush window.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_if.slave      bus,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     taken_count
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RESOLVE  = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam int              FC_W    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [15:0]      imm_q, imm_d;
    logic             invert_q, invert_d;
    logic             br_always_q, br_always_d;
    logic             cmp_nz_q, cmp_nz_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             resolved_q, resolved_d;
    logic             resolved_taken_q, resolved_taken_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [31:0] offset;
    logic [31:0] target;
    logic        taken;

    // Word offset: immediate shifted left by two and sign-extended to 32 bits.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_offset
            if (gi < 2) begin : g_zero
                assign offset[gi] = 1'b0;
            end else if (gi < 18) begin : g_imm
                assign offset[gi] = imm_q[gi-2];
            end else begin : g_sign
                assign offset[gi] = imm_q[15];
            end
        end
    endgenerate

    assign target = pc_q + 32'd4 + offset;
    assign taken  = br_always_q | (cmp_nz_q ^ invert_q);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        imm_d            = imm_q;
        invert_d         = invert_q;
        br_always_d      = br_always_q;
        cmp_nz_d         = cmp_nz_q;
        redirect_pc_d    = redirect_pc_q;
        resolved_d       = 1'b0;
        resolved_taken_d = resolved_taken_q;
        branch_count_d   = branch_count_q;
        taken_count_d    = taken_count_q;
        flush_cnt_d      = flush_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    pc_d        = bus.br_pc;
                    imm_d       = bus.br_imm;
                    invert_d    = bus.br_invert;
                    br_always_d = bus.br_always;
                    cmp_nz_d    = |bus.cmp_s;
                    state_d     = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                resolved_d       = 1'b1;
                resolved_taken_d = taken;
                branch_count_d   = branch_count_q + 1'b1;
                taken_count_d    = taken_count_q + {{(CNT_W-1){1'b0}}, taken};
                if (taken) begin
                    redirect_pc_d = target;
                    state_d       = ST_REDIRECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        flush_cnt_d = FC_LOAD;
                        state_d     = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                // Counter holds the flush cycles still to come, including this one.
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q <= FC_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            pc_q             <= '0;
            imm_q            <= '0;
            invert_q         <= 1'b0;
            br_always_q      <= 1'b0;
            cmp_nz_q         <= 1'b0;
            redirect_pc_q    <= '0;
            resolved_q       <= 1'b0;
            resolved_taken_q <= 1'b0;
            branch_count_q   <= '0;
            taken_count_q    <= '0;
            flush_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            imm_q            <= imm_d;
            invert_q         <= invert_d;
            br_always_q      <= br_always_d;
            cmp_nz_q         <= cmp_nz_d;
            redirect_pc_q    <= redirect_pc_d;
            resolved_q       <= resolved_d;
            resolved_taken_q <= resolved_taken_d;
            branch_count_q   <= branch_count_d;
            taken_count_q    <= taken_count_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign bus.br_ready       = (state_q == ST_IDLE);
    assign bus.redirect_valid = (state_q == ST_REDIRECT);
    assign bus.flush          = (state_q == ST_FLUSH);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.resolved       = resolved_q;
    assign bus.resolved_taken = resolved_taken_q;
    assign branch_count       = branch_count_q;
    assign taken_count        = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: two instances (short and long flush window) driven
// by the same directed vectors, checked every cycle against a transaction model.
module tb_branch_resolve;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [15:0] br_imm;
    logic        br_invert;
    logic        br_always;
    logic [31:0] cmp_s;
    logic        redirect_ready;

    int checks = 0;
    int errors = 0;

    branch_resolve_if ifc0 ();
    branch_resolve_if ifc1 ();
    logic [3:0]  bc0, tc0;
    logic [15:0] bc1, tc1;

    assign ifc0.br_valid = br_valid;       assign ifc1.br_valid = br_valid;
    assign ifc0.br_pc = br_pc;             assign ifc1.br_pc = br_pc;
    assign ifc0.br_imm = br_imm;           assign ifc1.br_imm = br_imm;
    assign ifc0.br_invert = br_invert;     assign ifc1.br_invert = br_invert;
    assign ifc0.br_always = br_always;     assign ifc1.br_always = br_always;
    assign ifc0.cmp_s = cmp_s;             assign ifc1.cmp_s = cmp_s;
    assign ifc0.redirect_ready = redirect_ready;
    assign ifc1.redirect_ready = redirect_ready;

    branch_resolve #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .bus(ifc0.slave), .branch_count(bc0), .taken_count(tc0)
    );
    branch_resolve #(.FLUSH_CYCLES(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .bus(ifc1.slave), .branch_count(bc1), .taken_count(tc1)
    );

    logic        dut_ready [2];
    logic        dut_rv    [2];
    logic        dut_fl    [2];
    logic        dut_res   [2];
    logic        dut_rt    [2];
    logic [31:0] dut_rpc   [2];
    logic [15:0] dut_bc    [2];
    logic [15:0] dut_tc    [2];

    assign dut_ready[0] = ifc0.br_ready;        assign dut_ready[1] = ifc1.br_ready;
    assign dut_rv[0]    = ifc0.redirect_valid;  assign dut_rv[1]    = ifc1.redirect_valid;
    assign dut_fl[0]    = ifc0.flush;           assign dut_fl[1]    = ifc1.flush;
    assign dut_res[0]   = ifc0.resolved;        assign dut_res[1]   = ifc1.resolved;
    assign dut_rt[0]    = ifc0.resolved_taken;  assign dut_rt[1]    = ifc1.resolved_taken;
    assign dut_rpc[0]   = ifc0.redirect_pc;     assign dut_rpc[1]   = ifc1.redirect_pc;
    assign dut_bc[0]    = {12'd0, bc0};         assign dut_bc[1]    = bc1;
    assign dut_tc[0]    = {12'd0, tc0};         assign dut_tc[1]    = tc1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending decision, one pending redirect, a flush budget.
    int          m_flush_len [2] = '{1, 3};
    int          m_cnt_w     [2] = '{4, 16};
    bit          m_decide    [2];
    bit          m_redir     [2];
    int          m_flush     [2];
    bit          m_res       [2];
    bit          m_taken     [2];
    logic [31:0] m_rpc       [2];
    longint      m_bc        [2];
    longint      m_tc        [2];
    logic [31:0] m_pc        [2];
    logic [15:0] m_imm       [2];
    bit          m_nz        [2];
    bit          m_inv       [2];
    bit          m_alw       [2];
    logic [31:0] m_tgt;
    longint      m_mask;
    bit          started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_mask = (64'sd1 <<< m_cnt_w[i]) - 1;
            if (reset) begin
                m_decide[i] = 0; m_redir[i] = 0; m_flush[i] = 0; m_res[i] = 0;
                m_taken[i] = 0;  m_rpc[i] = '0;  m_bc[i] = 0;    m_tc[i] = 0;
            end else begin
                m_res[i] = 0;
                if (m_decide[i]) begin
                    m_taken[i] = m_alw[i] || (m_nz[i] != m_inv[i]);
                    m_tgt = 32'(longint'(m_pc[i]) + 4 + longint'($signed(m_imm[i])) * 4);
                    m_res[i] = 1;
                    m_bc[i] = (m_bc[i] + 1) & m_mask;
                    if (m_taken[i]) begin
                        m_tc[i] = (m_tc[i] + 1) & m_mask;
                        m_redir[i] = 1;
                        m_rpc[i] = m_tgt;
                    end
                    m_decide[i] = 0;
                    $display("dut%0d branch pc=%h imm=%h taken=%0d target=%h",
                             i, m_pc[i], m_imm[i], m_taken[i], m_tgt);
                end else if (m_redir[i]) begin
                    if (redirect_ready) begin
                        m_redir[i] = 0;
                        m_flush[i] = m_flush_len[i];
                    end
                end else if (m_flush[i] > 0) begin
                    m_flush[i]--;
                end else if (br_valid) begin
                    m_pc[i] = br_pc; m_imm[i] = br_imm; m_inv[i] = br_invert;
                    m_alw[i] = br_always; m_nz[i] = (cmp_s != 32'd0);
                    m_decide[i] = 1;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("br_ready%0d", i), 32'(dut_ready[i]),
                    32'(!(m_decide[i] || m_redir[i] || m_flush[i] > 0)));
                chk($sformatf("redirect_valid%0d", i), 32'(dut_rv[i]), 32'(m_redir[i]));
                chk($sformatf("redirect_pc%0d", i), dut_rpc[i], m_rpc[i]);
                chk($sformatf("flush%0d", i), 32'(dut_fl[i]), 32'(m_flush[i] > 0));
                chk($sformatf("resolved%0d", i), 32'(dut_res[i]), 32'(m_res[i]));
                if (m_res[i]) chk($sformatf("resolved_taken%0d", i), 32'(dut_rt[i]), 32'(m_taken[i]));
                chk($sformatf("branch_count%0d", i), 32'(dut_bc[i]), 32'(m_bc[i]));
                chk($sformatf("taken_count%0d", i), 32'(dut_tc[i]), 32'(m_tc[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(dut_ready[0] === 1'b1 && dut_ready[1] === 1'b1) && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual br_ready=%b%b required 11", dut_ready[0], dut_ready[1]);
        end
    endtask

    // Presents one request while both instances are idle; returns in the RESOLVE cycle.
    task automatic send(input logic [31:0] pc, input logic [15:0] imm, input logic [31:0] c,
                        input logic inv, input logic alw);
        wait_idle();
        br_pc = pc; br_imm = imm; cmp_s = c; br_invert = inv; br_always = alw;
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [15:0] imm;
        logic [31:0] c;
        logic        inv;
        logic        taken;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [4] = '{
        '{32'h0000_1000, 16'h0005, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000},
        '{32'h0000_2000, 16'h8000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFE_2004},
        '{32'h0000_3000, 16'h0001, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_3008},
        '{32'h0000_4000, 16'h0002, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; br_valid = 1'b0; br_pc = '0; br_imm = '0; br_invert = 1'b0;
        br_always = 1'b0; cmp_s = '0; redirect_ready = 1'b0;
        repeat (3) tick();
        chk("reset_br_ready", 32'(dut_ready[0]), 32'd1);
        chk("reset_redirect_valid", 32'(dut_rv[0]), 32'd0);
        chk("reset_redirect_pc", dut_rpc[0], 32'd0);
        chk("reset_flush", 32'(dut_fl[0]), 32'd0);
        chk("reset_branch_count", 32'(dut_bc[0]), 32'd0);
        reset = 1'b0;
        tick();

        // Taken branch with a delayed redirect handshake.
        send(32'h0040_0010, 16'h0003, 32'd1, 1'b0, 1'b0);
        tick();
        chk("t1_resolved", 32'(dut_res[0]), 32'd1);
        chk("t1_taken", 32'(dut_rt[0]), 32'd1);
        chk("t1_target", dut_rpc[0], 32'h0040_0020);
        chk("t1_rv", 32'(dut_rv[0]), 32'd1);
        chk("t1_taken_count", 32'(dut_tc[0]), 32'd1);
        tick(); tick();
        chk("t1_rv_hold", 32'(dut_rv[0]), 32'd1);
        redirect_ready = 1'b1;
        tick();
        chk("t1_rv_drop", 32'(dut_rv[0]), 32'd0);
        chk("t1_flush_on", 32'(dut_fl[0]), 32'd1);
        redirect_ready = 1'b0;
        tick();
        chk("t1_flush_off0", 32'(dut_fl[0]), 32'd0);
        chk("t1_ready0", 32'(dut_ready[0]), 32'd1);
        chk("t1_flush_on1", 32'(dut_fl[1]), 32'd1);

        // Unconditional branches with negative offsets and address wrap.
        redirect_ready = 1'b1;
        send(32'h0000_0000, 16'hFFFF, 32'd0, 1'b0, 1'b1);
        tick();
        chk("t2_target_zero", dut_rpc[0], 32'h0000_0000);
        chk("t2_rv", 32'(dut_rv[0]), 32'd1);
        send(32'h0000_0000, 16'hFFFE, 32'd0, 1'b0, 1'b1);
        tick();
        chk("t2_target_wrap", dut_rpc[0], 32'hFFFF_FFFC);

        // Condition / invert combinations.
        foreach (vecs[n]) begin
            send(vecs[n].pc, vecs[n].imm, vecs[n].c, vecs[n].inv, 1'b0);
            tick();
            chk($sformatf("t3_taken%0d", n), 32'(dut_rt[0]), 32'(vecs[n].taken));
            if (vecs[n].taken) chk($sformatf("t3_target%0d", n), dut_rpc[0], vecs[n].tgt);
            else               chk($sformatf("t3_ready%0d", n), 32'(dut_ready[0]), 32'd1);
        end

        // Requests presented during a stalled redirect are ignored.
        redirect_ready = 1'b0;
        send(32'h0040_0010, 16'h0003, 32'd5, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 5; n++) begin
            br_valid = 1'b1; br_pc = 32'h1234_0000 + 32'(n * 16); cmp_s = 32'd1;
            tick();
            chk($sformatf("t4_ready%0d", n), 32'(dut_ready[0]), 32'd0);
            chk($sformatf("t4_pc%0d", n), dut_rpc[0], 32'h0040_0020);
        end
        br_valid = 1'b0;
        redirect_ready = 1'b1;
        tick();
        chk("t4_rv_drop", 32'(dut_rv[0]), 32'd0);

        // Reset during REDIRECT.
        redirect_ready = 1'b0;
        send(32'h0000_0100, 16'h0010, 32'd1, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("t5a_rv", 32'(dut_rv[0]), 32'd0);
        chk("t5a_ready", 32'(dut_ready[0]), 32'd1);
        chk("t5a_bc", 32'(dut_bc[0]), 32'd0);
        chk("t5a_tc", 32'(dut_tc[1]), 32'd0);
        reset = 1'b0;
        tick();

        // Reset during FLUSH.
        redirect_ready = 1'b1;
        send(32'h0000_0200, 16'h0010, 32'd1, 1'b0, 1'b0);
        tick(); tick();
        chk("t5b_in_flush", 32'(dut_fl[1]), 32'd1);
        reset = 1'b1;
        tick();
        chk("t5b_flush", 32'(dut_fl[0]), 32'd0);
        chk("t5b_flush1", 32'(dut_fl[1]), 32'd0);
        chk("t5b_ready", 32'(dut_ready[1]), 32'd1);
        chk("t5b_bc", 32'(dut_bc[1]), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 17 back-to-back not-taken branches: 4-bit counter wraps to 1.
        br_pc = 32'h0000_0800; br_imm = 16'h0001; cmp_s = 32'd0;
        br_invert = 1'b0; br_always = 1'b0;
        br_valid = 1'b1;
        repeat (34) tick();
        br_valid = 1'b0;
        tick();
        chk("t6_bc_wrap", 32'(dut_bc[0]), 32'd1);
        chk("t6_tc_wrap", 32'(dut_tc[0]), 32'd0);
        chk("t6_bc_wide", 32'(dut_bc[1]), 32'd17);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Sequential branch-resolution unit for the MIPS core. It consumes the condition word produced by the ALU compare paths, either a 0 or a non-zero value (EQ/NE/GTZ/LTZ/LEZ/GEZ-style ops), plus the branch PC and offset. It decides taken or not-taken and computes the branch target. On a taken branch it issues a handshaked redirect to fetch, followed by a programmable flush window. It sits between the ALU result path and the PC/fetch logic.

## Interface
Parameters:
- FLUSH_CYCLES, default 1: number of cycles `flush` is held after a redirect is accepted. 0 means no flush phase.
- CNT_W, default 16: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  1  branch request; all br_* inputs and cmp_s are valid.
- br_ready  out  1  block can accept a request this cycle.
- br_pc  in  32  PC of the branch instruction.
- br_imm  in  16  signed word offset from the instruction.
- br_invert  in  1  1: taken when cmp_s == 0; 0: taken when cmp_s != 0.
- br_always  in  1  1: taken regardless of cmp_s (J-style/unconditional).
- cmp_s  in  32  ALU compare result word.
- redirect_valid  out  1  redirect_pc is valid; fetch must switch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  32  branch target.
- flush  out  1  squash younger in-flight instructions.
- resolved  out  1  one-cycle pulse when a branch has been decided.
- resolved_taken  out  1  decision, valid while `resolved` is 1.
- branch_count  out  CNT_W  resolved branches, wrapping.
- taken_count  out  CNT_W  taken branches, wrapping.

## Operation
- States: IDLE, RESOLVE, REDIRECT, FLUSH.
- IDLE:
  - br_ready = 1.
  - On an edge with br_valid & br_ready: capture br_pc, br_imm, br_invert, br_always and cmp_s; go to RESOLVE.
- RESOLVE: lasts exactly one cycle.
  - taken = br_always | ((cmp_s != 0) ^ br_invert).
  - target = br_pc + 4 + (sign_extend(br_imm) << 2), modulo 2^32. Carries beyond bit 31 are discarded.
  - At the exit edge:
    - resolved <= 1 and resolved_taken <= taken.
    - branch_count += 1, and taken_count += taken.
    - If taken: redirect_pc <= target, redirect_valid <= 1, go to REDIRECT.
    - Otherwise: go to IDLE.
- REDIRECT:
  - Hold redirect_valid = 1 and redirect_pc stable until an edge with redirect_ready = 1.
  - At that edge: redirect_valid <= 0.
  - Then go to FLUSH if FLUSH_CYCLES > 0, else go to IDLE.
- FLUSH:
  - flush = 1 for exactly FLUSH_CYCLES cycles, tracked by a down-counter.
  - Then go to IDLE.
- br_ready = 1 only in IDLE. Requests presented outside IDLE are ignored and not queued.
- Counters wrap from 2^CNT_W-1 to 0. The two counters are independent.
- Only cmp_s == 0 versus cmp_s != 0 matters. Any non-zero value, for example 32'h8000_0000, counts as true.

## Timing
- Reset values: state IDLE, br_ready 1, redirect_valid 0, redirect_pc 0, flush 0, resolved 0, resolved_taken 0, both counters 0, flush counter 0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Accept edge E0. RESOLVE runs during the cycle after E0. Decision edge E1 = E0+1.
- resolved pulses high for the single cycle after E1.
- Not-taken branch: br_ready is 1 again after E1. Peak throughput is one branch per 2 cycles.
- Taken branch:
  - redirect_valid is high from E1.
  - The handshake edge Ek is the first edge ≥ E1+1 where redirect_ready = 1.
  - flush is high for cycles Ek+1 … Ek+FLUSH_CYCLES.
  - br_ready returns in the cycle after the last flush cycle, or right after Ek when FLUSH_CYCLES = 0.
- redirect_ready high before redirect_valid rises has no effect.
- Reset mid-operation, in any state, returns to the reset values on the next edge:
  - A pending redirect is dropped and flush deasserts.
  - The counters clear.

## Test plan
- Reset, then br_pc = 32'h0040_0010, br_imm = 16'h0003, cmp_s = 1, br_invert = 0 -> resolved = 1 and resolved_taken = 1 at E1. redirect_pc = 32'h0040_0020. redirect_valid held until redirect_ready; with FLUSH_CYCLES = 1, flush is high exactly one cycle; taken_count = 1.
- br_imm = 16'hFFFF, br_pc = 32'h0000_0000, br_always = 1 -> redirect_pc = 32'h0000_0000; br_imm = 16'hFFFE -> 32'hFFFF_FFFC (wrap).
- cmp_s = 0, br_invert = 0 -> not taken: no redirect, no flush, br_ready high 2 cycles after accept; branch_count +1, taken_count unchanged.
- redirect_ready held low for 5 cycles with new br_valid pulses during that time -> redirect_pc stable, br_ready stays 0, no extra counts; accept on cycle 6.
- Assert reset during REDIRECT and during FLUSH -> next cycle: redirect_valid = 0, flush = 0, br_ready = 1, counters = 0.
- Back-to-back not-taken requests with CNT_W = 4, 17 branches -> branch_count wraps to 1; taken_count = 0.
